// File: rtl/map_pkg.sv
// Shared map definitions: block types, tile geometry, FSM state codes and the hit update rule.
// AUTO_AIR_EN: when defined, a brick with every corner cleared becomes AIR.
package map_pkg;

  localparam int MAP_DIM = 13;
  localparam int TILE_W  = 7;

  typedef enum logic [2:0] {
    BRICK = 3'b000,
    WALL  = 3'b001,
    TREE  = 3'b010,
    WATER = 3'b011,
    AIR   = 3'b111
  } block_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_LOAD   = 2'd1;
  localparam state_t ST_HIT_RD = 2'd2;
  localparam state_t ST_HIT_WR = 2'd3;

  // Tile word after a hit clears the masked corners of a brick.
  function automatic logic [TILE_W-1:0] hit_tile(input logic [TILE_W-1:0] word,
                                                 input logic [3:0]        corner);
    logic [3:0] st;
    st = word[3:0] & ~corner;
`ifdef AUTO_AIR_EN
    if (st == 4'b0000) return {AIR, 4'b0000};
`endif
    return {word[6:4], st};
  endfunction

endpackage

// File: rtl/map_ctrl_rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters; the pointer moves past the winner on i_adv.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_adv,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IW-1:0]      o_idx,
  output logic               o_any
);

  logic [IW-1:0] r_ptr;

  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    o_gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!o_any && i_req[(int'(r_ptr) + i) % NUM_REQ]) begin
        o_any = 1'b1;
        o_idx = IW'((int'(r_ptr) + i) % NUM_REQ);
      end
    end
    if (o_any) o_gnt[o_idx] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      r_ptr <= '0;
    else if (i_adv)
      r_ptr <= (int'(o_idx) == NUM_REQ - 1) ? '0 : o_idx + 1'b1;
  end

endmodule

// File: rtl/map_ctrl.sv
// Tile map controller: streams a level from ROM into tile RAM and applies bullet hits.
// AUTO_AIR_EN: fully cleared bricks are rewritten as AIR instead of an empty brick.
module map_ctrl
  import map_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MAP_DIM = map_pkg::MAP_DIM
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     load_req_i,
  input  logic [1:0]               level_i,
  output logic [9:0]               rom_addr_o,
  input  logic [TILE_W-1:0]        rom_data_i,
  input  logic [NUM_REQ-1:0]       hit_req_i,
  input  logic [NUM_REQ-1:0][3:0]  hit_x_i,
  input  logic [NUM_REQ-1:0][3:0]  hit_y_i,
  input  logic [NUM_REQ-1:0][3:0]  hit_corner_i,
  output logic [NUM_REQ-1:0]       hit_ack_o,
  output logic [7:0]               tile_rd_addr_o,
  input  logic [TILE_W-1:0]        tile_rd_data_i,
  output logic                     tile_we_o,
  output logic [7:0]               tile_wr_addr_o,
  output logic [TILE_W-1:0]        tile_wr_data_o,
  output logic                     map_ready_o,
  output logic                     busy_o
);

  localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LAST = MAP_DIM * MAP_DIM - 1;

  state_t             r_state;
  logic               r_map_ready, r_ld_pend, r_wvld, r_oob;
  logic [1:0]         r_level;
  logic [7:0]         r_cnt, r_widx, r_tidx;
  logic [3:0]         r_corner;
  logic [NUM_REQ-1:0] r_gnt;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_gnt_idx;
  logic               w_any, w_ld_now, w_grant, w_enter_load, w_oob, w_brick;
  logic [3:0]         w_x, w_y, w_c;
  logic [7:0]         w_tidx;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .i_req   (hit_req_i),
    .i_adv   (w_grant),
    .o_gnt   (w_gnt),
    .o_idx   (w_gnt_idx),
    .o_any   (w_any)
  );

  assign w_x    = hit_x_i[w_gnt_idx];
  assign w_y    = hit_y_i[w_gnt_idx];
  assign w_c    = hit_corner_i[w_gnt_idx];
  assign w_oob  = (int'(w_x) >= MAP_DIM) || (int'(w_y) >= MAP_DIM);
  assign w_tidx = 8'(int'(w_y) * MAP_DIM + int'(w_x));

  // A load requested mid-hit is held until the hit has acked; a load during LOAD restarts it.
  assign w_ld_now     = load_req_i | r_ld_pend;
  assign w_enter_load = w_ld_now & ((r_state != ST_HIT_RD) | r_oob);
  assign w_grant      = (r_state == ST_IDLE) & ~w_ld_now & r_map_ready & w_any;

  assign w_brick        = (tile_rd_data_i[6:4] == BRICK);
  assign rom_addr_o     = {r_level, r_cnt};
  assign tile_rd_addr_o = r_tidx;
  assign tile_we_o      = ((r_state == ST_LOAD) & r_wvld) | ((r_state == ST_HIT_WR) & w_brick);
  assign tile_wr_addr_o = (r_state == ST_HIT_WR) ? r_tidx : r_widx;
  assign tile_wr_data_o = (r_state == ST_HIT_WR) ? hit_tile(tile_rd_data_i, r_corner) : rom_data_i;
  assign hit_ack_o      = (((r_state == ST_HIT_RD) & r_oob) | (r_state == ST_HIT_WR)) ? r_gnt : '0;
  assign map_ready_o    = r_map_ready;
  assign busy_o         = (r_state != ST_IDLE);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= ST_IDLE;
      r_map_ready <= 1'b0;
      r_ld_pend   <= 1'b0;
      r_wvld      <= 1'b0;
      r_oob       <= 1'b0;
      r_level     <= '0;
      r_cnt       <= '0;
      r_widx      <= '0;
      r_tidx      <= '0;
      r_corner    <= '0;
      r_gnt       <= '0;
    end else begin
      if (load_req_i) r_level <= level_i;
      if (w_enter_load) begin
        r_state     <= ST_LOAD;
        r_cnt       <= '0;
        r_wvld      <= 1'b0;
        r_map_ready <= 1'b0;
        r_ld_pend   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: if (w_grant) begin
            r_state  <= ST_HIT_RD;
            r_gnt    <= w_gnt;
            r_tidx   <= w_tidx;
            r_corner <= w_c;
            r_oob    <= w_oob;
          end
          // ROM word for index n arrives one cycle after its address, so the write trails by one.
          ST_LOAD: if (int'(r_cnt) <= LAST) begin
            r_cnt  <= r_cnt + 8'd1;
            r_wvld <= 1'b1;
            r_widx <= r_cnt;
          end else begin
            r_wvld      <= 1'b0;
            r_map_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
          ST_HIT_RD: begin
            r_state <= r_oob ? ST_IDLE : ST_HIT_WR;
            if (load_req_i) r_ld_pend <= 1'b1;
          end
          ST_HIT_WR: r_state <= ST_IDLE;
          default:   r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_map_ctrl.sv
// Scoreboard bench for map_ctrl: stimulus queues expected writes/acks/levels, a negedge monitor checks them.
module tb_map_ctrl;

  logic            clk_i;
  logic            reset_i;
  logic            load_req_i;
  logic [1:0]      level_i;
  logic [9:0]      rom_addr_o;
  logic [6:0]      rom_data_i;
  logic [3:0]      hit_req_i;
  logic [3:0][3:0] hit_x_i, hit_y_i, hit_corner_i;
  logic [3:0]      hit_ack_o;
  logic [7:0]      tile_rd_addr_o;
  logic [6:0]      tile_rd_data_i;
  logic            tile_we_o;
  logic [7:0]      tile_wr_addr_o;
  logic [6:0]      tile_wr_data_o;
  logic            map_ready_o;
  logic            busy_o;

  map_ctrl #(.NUM_REQ(4), .MAP_DIM(13)) dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .load_req_i     (load_req_i),
    .level_i        (level_i),
    .rom_addr_o     (rom_addr_o),
    .rom_data_i     (rom_data_i),
    .hit_req_i      (hit_req_i),
    .hit_x_i        (hit_x_i),
    .hit_y_i        (hit_y_i),
    .hit_corner_i   (hit_corner_i),
    .hit_ack_o      (hit_ack_o),
    .tile_rd_addr_o (tile_rd_addr_o),
    .tile_rd_data_i (tile_rd_data_i),
    .tile_we_o      (tile_we_o),
    .tile_wr_addr_o (tile_wr_addr_o),
    .tile_wr_data_o (tile_wr_data_o),
    .map_ready_o    (map_ready_o),
    .busy_o         (busy_o)
  );

`ifdef AUTO_AIR_EN
  localparam int CLEAR_EXP = 'h70;
`else
  localparam int CLEAR_EXP = 'h00;
`endif

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ROM and tile RAM, both with one cycle of read latency
  logic [6:0] rom [0:1023];
  logic [6:0] ram [0:255];
  always @(posedge clk_i) rom_data_i <= rom[rom_addr_o];
  always @(posedge clk_i) begin
    if (tile_we_o) ram[tile_wr_addr_o] <= tile_wr_data_o;
    tile_rd_data_i <= ram[tile_rd_addr_o];
  end

  typedef struct {int cyc; int addr; int data;} wr_t;
  typedef struct {int cyc; int val;} ack_t;
  typedef struct {int cyc; int sel; int val;} lvl_t;
  wr_t  exp_wr[$];
  ack_t exp_ack[$];
  lvl_t exp_lvl[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic flag(input string nm, input int val);
    checks++;
    failures++;
    $display("FAIL %s cyc=%0d value=%0h", nm, cyc, val);
  endtask

  function automatic string sel_name(input int sel);
    case (sel)
      0: return "map_ready";
      1: return "busy";
      2: return "rom_addr";
      3: return "tile_rd_addr";
      4: return "tile_wr_addr";
      5: return "tile_we";
      6: return "hit_ack";
      default: return "queues_drained";
    endcase
  endfunction

  // Monitor: all comparisons happen here, away from the active edge
  always @(negedge clk_i) begin
    wr_t  w;
    ack_t a;
    lvl_t l;
    int   act;
    while (exp_wr.size() > 0 && exp_wr[0].cyc < cyc) begin
      w = exp_wr.pop_front();
      flag("wr_missing_addr", w.addr);
    end
    while (exp_ack.size() > 0 && exp_ack[0].cyc < cyc) begin
      a = exp_ack.pop_front();
      flag("ack_missing", a.val);
    end
    if (tile_we_o) begin
      if (exp_wr.size() > 0 && exp_wr[0].cyc == cyc) begin
        w = exp_wr.pop_front();
        check("wr_addr", int'(tile_wr_addr_o), w.addr);
        check("wr_data", int'(tile_wr_data_o), w.data);
      end else
        flag("wr_unexpected_addr", int'(tile_wr_addr_o));
    end
    if (hit_ack_o != 4'b0000) begin
      check("ack_onehot", int'($onehot(hit_ack_o)), 1);
      if (exp_ack.size() > 0 && exp_ack[0].cyc == cyc) begin
        a = exp_ack.pop_front();
        check("ack_who", int'(hit_ack_o), a.val);
      end else
        flag("ack_unexpected", int'(hit_ack_o));
    end
    while (exp_lvl.size() > 0 && exp_lvl[0].cyc <= cyc) begin
      l = exp_lvl.pop_front();
      case (l.sel)
        0: act = int'(map_ready_o);
        1: act = int'(busy_o);
        2: act = int'(rom_addr_o);
        3: act = int'(tile_rd_addr_o);
        4: act = int'(tile_wr_addr_o);
        5: act = int'(tile_we_o);
        6: act = int'(hit_ack_o);
        default: act = exp_wr.size() + exp_ack.size();
      endcase
      check(sel_name(l.sel), act, l.val);
    end
  end

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic lvl(input int c, input int sel, input int val);
    exp_lvl.push_back('{c, sel, val});
  endtask

  task automatic push_load(input int lv, input int e, input int n);
    for (int k = 0; k < n; k++) exp_wr.push_back('{e + 1 + k, k, int'(rom[lv * 256 + k])});
  endtask

  task automatic do_load(input int lv);
    int e;
    e = cyc + 1;
    push_load(lv, e, 169);
    lvl(e, 2, lv * 256);
    lvl(e, 0, 0);
    lvl(e + 169, 0, 0);
    lvl(e + 170, 0, 1);
    lvl(e + 170, 1, 0);
    load_req_i = 1'b1;
    level_i    = 2'(lv);
    tick;
    load_req_i = 1'b0;
    repeat (170) tick;
  endtask

  task automatic run_hits(input int budget);
    for (int i = 0; i < budget && hit_req_i != 4'b0000; i++) begin
      tick;
      hit_req_i = hit_req_i & ~hit_ack_o;
    end
    hit_req_i = '0;
  endtask

  task automatic hit1(input int r, input int x, input int y, input int cm,
                      input int ack_off, input bit wr, input int addr, input int data);
    int c;
    tick;
    c = cyc;
    if (wr) exp_wr.push_back('{c + ack_off, addr, data});
    exp_ack.push_back('{c + ack_off, 1 << r});
    hit_x_i[r]      = 4'(x);
    hit_y_i[r]      = 4'(y);
    hit_corner_i[r] = 4'(cm);
    hit_req_i[r]    = 1'b1;
    run_hits(10);
  endtask

  initial begin
    int c, e;
    reset_i      = 1'b0;
    load_req_i   = 1'b0;
    level_i      = '0;
    hit_req_i    = '0;
    hit_x_i      = '0;
    hit_y_i      = '0;
    hit_corner_i = '0;
    for (int a = 0; a < 1024; a++) rom[a] = 7'b001_0000;
    for (int k = 0; k < 169; k++) rom[256 + k] = 7'(k);
    rom[512 + 15] = 7'b000_1111;
    for (int k = 20; k < 24; k++) rom[512 + k] = 7'b000_1111;
    rom[512 + 30] = 7'b001_1111;
    rom[512 + 40] = 7'b000_1111;
    #1 reset_i = 1'b1;

    // reset state
    for (int s = 0; s < 7; s++) lvl(2, s, 0);
    repeat (3) tick;
    reset_i = 1'b0;
    lvl(cyc + 3, 1, 0);
    lvl(cyc + 3, 0, 0);
    repeat (5) tick;

    // level 1 with index-valued ROM words, then level 2 with the hit targets
    do_load(1);
    do_load(2);

    // four simultaneous requesters: acks 0,1,2,3 every 3 cycles
    tick;
    c = cyc;
    for (int r = 0; r < 4; r++) begin
      exp_wr.push_back('{c + 2 + 3 * r, 20 + r, 15 & ~(1 << r)});
      exp_ack.push_back('{c + 2 + 3 * r, 1 << r});
      hit_x_i[r]      = 4'(7 + r);
      hit_y_i[r]      = 4'd1;
      hit_corner_i[r] = 4'(1 << r);
    end
    hit_req_i = 4'hF;
    run_hits(30);

    hit1(0, 2, 1, 1, 2, 1'b1, 15, 'h0E);        // brick, UL cleared
    hit1(1, 4, 2, 1, 2, 1'b0, 0, 0);            // wall: ack only
    hit1(2, 13, 0, 1, 1, 1'b0, 0, 0);           // off-map column: early ack
    hit1(3, 1, 3, 15, 2, 1'b1, 40, CLEAR_EXP);  // all corners cleared

    // reset while index 80 is being fetched
    tick;
    e = cyc + 1;
    push_load(1, e, 79);
    load_req_i = 1'b1;
    level_i    = 2'd1;
    tick;
    load_req_i = 1'b0;
    repeat (80) tick;
    reset_i = 1'b1;
    lvl(cyc, 5, 0);
    lvl(cyc, 0, 0);
    lvl(cyc + 1, 1, 0);
    lvl(cyc + 1, 2, 0);
    tick;
    tick;
    reset_i = 1'b0;
    lvl(cyc + 5, 1, 0);
    lvl(cyc + 5, 0, 0);
    repeat (20) tick;

    // load request during HIT_RD: hit completes, then LOAD
    do_load(2);
    tick;
    c = cyc;
    e = c + 3;
    exp_wr.push_back('{c + 2, 15, 'h0E});
    exp_ack.push_back('{c + 2, 1});
    lvl(c + 3, 0, 0);
    lvl(c + 3, 1, 1);
    lvl(c + 3, 2, 512);
    push_load(2, e, 169);
    lvl(e + 170, 0, 1);
    hit_x_i[0]      = 4'd2;
    hit_y_i[0]      = 4'd1;
    hit_corner_i[0] = 4'd1;
    hit_req_i       = 4'b0001;
    tick;
    load_req_i = 1'b1;
    level_i    = 2'd2;
    tick;
    load_req_i = 1'b0;
    hit_req_i  = hit_req_i & ~hit_ack_o;
    repeat (171) tick;
    hit_req_i = '0;

    lvl(cyc + 1, 7, 0);
    repeat (3) tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
